// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: operands, opcode and tag in; result, flags and tag out.
// No storage; pure signal grouping.
// Back-pressure through in_ready/out_ready valid-ready pairs.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  // Producer/consumer side (issue logic and writeback arbiter)
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_carry, out_ovf, out_zero
  );

  // ALU side
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_carry, out_ovf, out_zero
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined 8-op ALU with carry/overflow/zero flags and a pass-through request tag.
// Latency PIPE_STAGES cycles from accepting edge; one op per cycle when not stalled.
// Stalled stages hold; bubbles are squeezed out; in_ready drops only when every stage is full.
module alu_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             carry;
    logic             ovf;
    logic             zero;
  } stage_t;

  stage_t                 st [PIPE_STAGES];
  stage_t                 alu;
  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:0] rdy;
  logic                   up;
  logic                   take;
  logic [WIDTH-1:0]       b_eff;
  logic                   cin;
  logic [WIDTH:0]         sum;
  logic                   arith_ovf;

  // Stage k may load when it or any later stage has a hole, or the consumer drains the last one.
  // Written as a direct OR-reduction rather than a ripple chain to keep the logic loop-free.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      rdy[k] = bus.out_ready || (((~vld) >> k) != '0);
    end
  end

  // up holds off acceptance until the first edge after reset release.
  assign bus.in_ready = up && rdy[0];
  assign take         = bus.in_valid && bus.in_ready;

  // Compute the result and flags of the presented op; SUB reuses the adder as A + ~B + 1.
  always_comb begin
    cin       = (bus.in_op == 3'b001);
    b_eff     = cin ? ~bus.in_b : bus.in_b;
    sum       = {1'b0, bus.in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    arith_ovf = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
    alu       = '0;
    alu.tag   = bus.in_tag;
    case (bus.in_op)
      3'b000, 3'b001: begin
        alu.result = sum[WIDTH-1:0];
        alu.carry  = sum[WIDTH];
        alu.ovf    = arith_ovf;
      end
      3'b010:  alu.result = {{(WIDTH-1){1'b0}}, (bus.in_a > bus.in_b)};
      3'b011:  alu.result = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) > $signed(bus.in_b))};
      3'b100:  alu.result = bus.in_a & bus.in_b;
      3'b101:  alu.result = bus.in_a | bus.in_b;
      3'b110:  alu.result = bus.in_a ^ bus.in_b;
      default: alu.result = {{(WIDTH-1){1'b0}}, (bus.in_a == bus.in_b)};
    endcase
    alu.zero = (alu.result == '0);
  end

  // Pipeline registers: stage 0 captures the ALU output, later stages are pure delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up  <= 1'b0;
      vld <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        st[k] <= '0;
      end
    end else begin
      up <= 1'b1;
      if (rdy[0]) begin
        vld[0] <= take;
        if (take) begin
          st[0] <= alu;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            st[k] <= st[k-1];
          end
        end
      end
    end
  end

  assign bus.out_valid  = vld[PIPE_STAGES-1];
  assign bus.out_result = st[PIPE_STAGES-1].result;
  assign bus.out_tag    = st[PIPE_STAGES-1].tag;
  assign bus.out_carry  = st[PIPE_STAGES-1].carry;
  assign bus.out_ovf    = st[PIPE_STAGES-1].ovf;
  assign bus.out_zero   = st[PIPE_STAGES-1].zero;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: four instances (32b/2 stages, 32b/1, 32b/4, 8b/2) share one stimulus.
// Directed checks run on the 32b/2-stage instance; the stream test checks all four.
// Inputs driven at posedge+1, outputs sampled at posedge+3.
module tb_alu_pipe;

  localparam int N = 100;
  localparam int PD [4] = '{2, 1, 4, 2};

  logic        clk;
  logic        rst_n;
  logic        drv_vld;
  logic        drv_ordy;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic [2:0]  drv_op;
  logic [3:0]  drv_tag;

  int errors;
  int checks;

  alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus2 ();
  alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus1 ();
  alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus4 ();
  alu_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

  alu_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  alu_pipe #(.WIDTH(32), .PIPE_STAGES(1), .TAG_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_pipe #(.WIDTH(32), .PIPE_STAGES(4), .TAG_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  alu_pipe #(.WIDTH(8),  .PIPE_STAGES(2), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  assign bus2.in_valid = drv_vld;  assign bus2.in_a = drv_a;      assign bus2.in_b = drv_b;
  assign bus2.in_op = drv_op;      assign bus2.in_tag = drv_tag;  assign bus2.out_ready = drv_ordy;
  assign bus1.in_valid = drv_vld;  assign bus1.in_a = drv_a;      assign bus1.in_b = drv_b;
  assign bus1.in_op = drv_op;      assign bus1.in_tag = drv_tag;  assign bus1.out_ready = drv_ordy;
  assign bus4.in_valid = drv_vld;  assign bus4.in_a = drv_a;      assign bus4.in_b = drv_b;
  assign bus4.in_op = drv_op;      assign bus4.in_tag = drv_tag;  assign bus4.out_ready = drv_ordy;
  assign bus8.in_valid = drv_vld;  assign bus8.in_a = drv_a[7:0]; assign bus8.in_b = drv_b[7:0];
  assign bus8.in_op = drv_op;      assign bus8.in_tag = drv_tag;  assign bus8.out_ready = drv_ordy;

  // Per-instance output views so the stream check can loop over instances.
  logic [63:0] o_res [4];
  logic        o_vld [4];
  logic        o_c   [4];
  logic        o_v   [4];
  logic        o_z   [4];
  logic        o_rdy [4];
  logic [3:0]  o_tag [4];

  assign o_res[0] = {32'b0, bus2.out_result}; assign o_vld[0] = bus2.out_valid; assign o_c[0] = bus2.out_carry;
  assign o_v[0] = bus2.out_ovf; assign o_z[0] = bus2.out_zero; assign o_tag[0] = bus2.out_tag; assign o_rdy[0] = bus2.in_ready;
  assign o_res[1] = {32'b0, bus1.out_result}; assign o_vld[1] = bus1.out_valid; assign o_c[1] = bus1.out_carry;
  assign o_v[1] = bus1.out_ovf; assign o_z[1] = bus1.out_zero; assign o_tag[1] = bus1.out_tag; assign o_rdy[1] = bus1.in_ready;
  assign o_res[2] = {32'b0, bus4.out_result}; assign o_vld[2] = bus4.out_valid; assign o_c[2] = bus4.out_carry;
  assign o_v[2] = bus4.out_ovf; assign o_z[2] = bus4.out_zero; assign o_tag[2] = bus4.out_tag; assign o_rdy[2] = bus4.in_ready;
  assign o_res[3] = {56'b0, bus8.out_result}; assign o_vld[3] = bus8.out_valid; assign o_c[3] = bus8.out_carry;
  assign o_v[3] = bus8.out_ovf; assign o_z[3] = bus8.out_zero; assign o_tag[3] = bus8.out_tag; assign o_rdy[3] = bus8.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU for width w (w <= 32); SUB overflow uses the operand-sign rule, GTS a sign-bias compare.
  function automatic void model(input logic [63:0] a_in, input logic [63:0] b_in, input logic [2:0] op,
                                input int w, output logic [63:0] res, output logic c, output logic v);
    logic [64:0] s;
    logic [63:0] mask, sbit, a, b;
    mask = (64'd1 << w) - 64'd1;
    sbit = 64'd1 << (w - 1);
    a    = a_in & mask;
    b    = b_in & mask;
    c    = 1'b0;
    v    = 1'b0;
    res  = 64'd0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        res = s[63:0] & mask; c = s[w];
        v = (a[w-1] == b[w-1]) && (res[w-1] != a[w-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, (~b & mask)} + 65'd1;
        res = s[63:0] & mask; c = s[w];
        v = (a[w-1] != b[w-1]) && (res[w-1] != a[w-1]);
      end
      3'd2: res = (a > b) ? 64'd1 : 64'd0;
      3'd3: res = ((a ^ sbit) > (b ^ sbit)) ? 64'd1 : 64'd0;
      3'd4: res = a & b;
      3'd5: res = a | b;
      3'd6: res = a ^ b;
      default: res = (a == b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drv_vld = 1'b0; drv_ordy = 1'b0;
    drv_a = '0; drv_b = '0; drv_op = '0; drv_tag = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (bus2.out_valid !== 1'b0 || bus2.out_result !== 32'd0 || bus2.out_tag !== 4'd0 ||
        bus2.out_carry !== 1'b0 || bus2.out_ovf !== 1'b0 || bus2.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b res=%h tag=%h c=%b v=%b z=%b, want all 0", bus2.out_valid,
               bus2.out_result, bus2.out_tag, bus2.out_carry, bus2.out_ovf, bus2.out_zero);
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if (bus2.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_rdy_early: got %b want 0", bus2.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus2.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_rdy: got %b want 1", bus2.in_ready);
    end
  endtask

  task automatic test_ops();
    logic [31:0] va [9] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h3, 32'h8000_0000, 32'h8000_0000,
                            32'h1234, 32'hAAAA_AAAA, 32'hF0F0_FFFF, 32'hF000_0000};
    logic [31:0] vb [9] = '{32'h1, 32'h1, 32'h5, 32'h1, 32'h1, 32'h1234, 32'hAAAA_AAAA,
                            32'h0FF0_00FF, 32'h0000_000F};
    logic [2:0]  vo [9] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd7, 3'd6, 3'd4, 3'd5};
    logic [31:0] er [9] = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h1, 32'h0,
                            32'h00F0_00FF, 32'hF000_000F};
    logic        ec [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ev [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ez [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    drv_ordy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drv_a = va[i]; drv_b = vb[i]; drv_op = vo[i]; drv_tag = 4'(i + 5); drv_vld = 1'b1;
      @(posedge clk); #1;
      drv_vld = 1'b0;
      #2;
      checks++;
      if (bus2.out_valid !== 1'b0) begin
        errors++; $display("FAIL op%0d_early_valid: got %b want 0", i, bus2.out_valid);
      end
      @(posedge clk); #3;
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.out_result !== er[i] || bus2.out_carry !== ec[i] ||
          bus2.out_ovf !== ev[i] || bus2.out_zero !== ez[i] || bus2.out_tag !== 4'(i + 5)) begin
        errors++;
        $display("FAIL op%0d_result: got vld=%b res=%h c=%b v=%b z=%b tag=%0d, want vld=1 res=%h c=%b v=%b z=%b tag=%0d",
                 i, bus2.out_valid, bus2.out_result, bus2.out_carry, bus2.out_ovf, bus2.out_zero, bus2.out_tag,
                 er[i], ec[i], ev[i], ez[i], i + 5);
      end
      #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int nxt, nrx;
    logic acc;
    logic [3:0]  rx_tag [8];
    logic [31:0] rx_res [8];
    do_reset();
    nxt = 0; nrx = 0;
    drv_ordy = 1'b0; drv_vld = 1'b1; drv_op = 3'd0; drv_a = 32'd0; drv_b = 32'd1; drv_tag = 4'd0;
    for (int c = 0; c < 4; c++) begin
      #2;
      acc = bus2.in_ready && drv_vld;
      if (c >= 2) begin
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_tag !== 4'd0 || bus2.out_result !== 32'd1) begin
          errors++;
          $display("FAIL stall_hold_c%0d: got vld=%b tag=%0d res=%h want vld=1 tag=0 res=1", c,
                   bus2.out_valid, bus2.out_tag, bus2.out_result);
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        nxt++;
        drv_a = 32'(nxt * 16); drv_tag = 4'(nxt); drv_vld = (nxt < 4);
      end
    end
    #2;
    checks++;
    if (nxt !== 2 || bus2.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_fill: accepted %0d in_ready=%b, want 2 and 0", nxt, bus2.in_ready);
    end
    drv_ordy = 1'b1;
    #1;
    checks++;
    if (bus2.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_drain_accept: in_ready=%b want 1", bus2.in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) #3;
      acc = bus2.in_ready && drv_vld;
      if (bus2.out_valid && drv_ordy && nrx < 8) begin
        rx_tag[nrx] = bus2.out_tag; rx_res[nrx] = bus2.out_result; nrx++;
      end
      @(posedge clk); #1;
      if (acc) begin
        nxt++;
        drv_a = 32'(nxt * 16); drv_tag = 4'(nxt); drv_vld = (nxt < 4);
      end
    end
    checks++;
    if (nrx !== 4) begin
      errors++; $display("FAIL drain_count: got %0d results want 4", nrx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= nrx || rx_tag[i] !== 4'(i) || rx_res[i] !== 32'(i * 16 + 1)) begin
        errors++;
        $display("FAIL drain_order%0d: got tag=%0d res=%h want tag=%0d res=%h", i,
                 (i < nrx) ? rx_tag[i] : 4'hx, (i < nrx) ? rx_res[i] : 32'hx, i, i * 16 + 1);
      end
    end
    drv_vld = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] sa [N];
    logic [31:0] sb [N];
    logic [2:0]  sop [N];
    logic [3:0]  stag [N];
    logic [63:0] e32r [N];
    logic [63:0] e8r [N];
    logic        e32c [N];
    logic        e32v [N];
    logic        e8c [N];
    logic        e8v [N];
    logic [63:0] r;
    logic        c, v, ok;
    int idx;
    for (int i = 0; i < N; i++) begin
      sa[i] = $urandom;
      sb[i] = (i % 5 == 0) ? sa[i] : $urandom;
      sop[i] = 3'($urandom_range(0, 7));
      stag[i] = 4'(i % 16);
      model({32'b0, sa[i]}, {32'b0, sb[i]}, sop[i], 32, r, c, v);
      e32r[i] = r; e32c[i] = c; e32v[i] = v;
      model({32'b0, sa[i]}, {32'b0, sb[i]}, sop[i], 8, r, c, v);
      e8r[i] = r; e8c[i] = c; e8v[i] = v;
    end
    do_reset();
    drv_ordy = 1'b1;
    for (int j = 0; j < N + 5; j++) begin
      if (j < N) begin
        drv_vld = 1'b1; drv_a = sa[j]; drv_b = sb[j]; drv_op = sop[j]; drv_tag = stag[j];
      end else begin
        drv_vld = 1'b0;
      end
      #2;
      checks++;
      if (o_rdy[0] !== 1'b1 || o_rdy[1] !== 1'b1 || o_rdy[2] !== 1'b1 || o_rdy[3] !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready cyc%0d: got %b%b%b%b want 1111", j, o_rdy[0], o_rdy[1], o_rdy[2], o_rdy[3]);
      end
      for (int d = 0; d < 4; d++) begin
        idx = j - PD[d];
        checks++;
        if (idx >= 0 && idx < N) begin
          r = (d == 3) ? e8r[idx] : e32r[idx];
          c = (d == 3) ? e8c[idx] : e32c[idx];
          v = (d == 3) ? e8v[idx] : e32v[idx];
          ok = (o_vld[d] === 1'b1) && (o_res[d] === r) && (o_c[d] === c) && (o_v[d] === v) &&
               (o_z[d] === (r == 64'd0)) && (o_tag[d] === stag[idx]);
          if (!ok) begin
            errors++;
            $display("FAIL stream_d%0d_op%0d: got vld=%b res=%h c=%b v=%b z=%b tag=%0d, want vld=1 res=%h c=%b v=%b z=%b tag=%0d",
                     d, idx, o_vld[d], o_res[d], o_c[d], o_v[d], o_z[d], o_tag[d], r, c, v, (r == 64'd0), stag[idx]);
          end
        end else if (o_vld[d] !== 1'b0) begin
          errors++; $display("FAIL stream_d%0d_idle cyc%0d: out_valid=%b want 0", d, j, o_vld[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drv_ordy = 1'b1;
    drv_vld = 1'b1; drv_op = 3'd0; drv_a = 32'd1; drv_b = 32'd2; drv_tag = 4'd7;
    @(posedge clk); #1;
    drv_a = 32'd5; drv_b = 32'd5; drv_tag = 4'd8;
    @(posedge clk); #1;
    drv_vld = 1'b0;
    checks++;
    if (bus2.out_valid !== 1'b1 || bus2.out_result !== 32'd3) begin
      errors++; $display("FAIL midop_inflight: got vld=%b res=%h want 1 and 3", bus2.out_valid, bus2.out_result);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus2.out_valid !== 1'b0 || bus2.out_result !== 32'd0 || bus2.out_tag !== 4'd0 ||
        bus2.out_carry !== 1'b0 || bus2.out_ovf !== 1'b0 || bus2.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_clear: got vld=%b res=%h tag=%h c=%b v=%b z=%b, want all 0", bus2.out_valid,
               bus2.out_result, bus2.out_tag, bus2.out_carry, bus2.out_ovf, bus2.out_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      checks++;
      if (bus2.out_valid !== 1'b0) begin
        errors++; $display("FAIL midop_stale_c%0d: out_valid=%b want 0", c, bus2.out_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus2.in_ready !== 1'b1) begin
      errors++; $display("FAIL midop_rdy_after: in_ready=%b want 1", bus2.in_ready);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ops();
    test_backpressure();
    test_stream();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
